pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 12 +
 rtl/pipe_ctrl_lu_detect.sv | 17 +
 rtl/pipe_ctrl.sv | 104 ++++++++++
 tb/tb_pipe_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard/flush controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W     = 5;
  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic {
    RUN = 1'b0,
    LU  = 1'b1
  } state_t;

endpackage

// File: rtl/pipe_ctrl_lu_detect.sv
// Load-use hazard comparator: the load in EX writes a register the ID instruction reads.
module lu_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             lu_haz
);

  // Register zero is never a real dependency.
  assign lu_haz = ex_memread && (ex_rt != '0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: load-use stall, redirect flush, external hold, with event counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_redirect,
  input  logic             ext_hold,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             pipe_we,
  output logic             ex_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t state, state_nxt;
  logic   lu_haz;
  logic   ex_valid_nxt;
  logic   stall_inc;
  logic   flush_inc;

  lu_detect u_lu_detect (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .lu_haz     (lu_haz)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      ex_valid  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ex_valid <= ex_valid_nxt;
      if (stall_inc && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_inc && (flush_cnt != {CNT_W{1'b1}})) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  // Priority: rst > ext_hold > mem_redirect > load-use (RUN only) > normal flow.
  always_comb begin
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    pipe_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_flush  = 1'b0;
    state_nxt    = state;
    ex_valid_nxt = ex_valid;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
      state_nxt   = RUN;
    end else if (ext_hold) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      pipe_we = 1'b0;
    end else if (mem_redirect) begin
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_flush  = 1'b1;
      state_nxt    = RUN;
      ex_valid_nxt = 1'b0;
      flush_inc    = 1'b1;
    end else if ((state == RUN) && lu_haz) begin
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_bubble  = 1'b1;
      state_nxt    = LU;
      ex_valid_nxt = 1'b0;
      stall_inc    = 1'b1;
    end else begin
      state_nxt    = RUN;
      ex_valid_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: default-width and 2-bit-counter instances against a rule-level model.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_memread, mem_redirect, ext_hold;

  logic        pc_we_a, ifid_we_a, ifid_flush_a, idex_bubble_a, exmem_flush_a, pipe_we_a, ex_valid_a;
  logic [15:0] stall_cnt_a, flush_cnt_a;
  logic        pc_we_b, ifid_we_b, ifid_flush_b, idex_bubble_b, exmem_flush_b, pipe_we_b, ex_valid_b;
  logic [1:0]  stall_cnt_b, flush_cnt_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_redirect(mem_redirect), .ext_hold(ext_hold),
    .pc_we(pc_we_a), .ifid_we(ifid_we_a), .ifid_flush(ifid_flush_a), .idex_bubble(idex_bubble_a),
    .exmem_flush(exmem_flush_a), .pipe_we(pipe_we_a), .ex_valid(ex_valid_a),
    .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
  );

  pipe_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_redirect(mem_redirect), .ext_hold(ext_hold),
    .pc_we(pc_we_b), .ifid_we(ifid_we_b), .ifid_flush(ifid_flush_b), .idex_bubble(idex_bubble_b),
    .exmem_flush(exmem_flush_b), .pipe_we(pipe_we_b), .ex_valid(ex_valid_b),
    .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
  );

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_ok = 0;        // model state is defined (after first reset edge)
  bit m_stalled = 0;   // previous cycle spent its one stall on a hazard
  bit m_ev = 0;
  int m_stall = 0, m_flush = 0;

  function automatic bit hazard();
    if (!ex_memread || ex_rt == 5'd0) return 1'b0;
    if (ex_rt == id_rs) return 1'b1;
    return id_uses_rt && (ex_rt == id_rt);
  endfunction

  function automatic int sat(input int n, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
  endfunction

  // Expected {pc_we, ifid_we, pipe_we, ifid_flush, idex_bubble, exmem_flush}
  function automatic logic [5:0] exp_ctl();
    if (rst)                        return 6'b001_111;
    if (ext_hold)                   return 6'b000_000;
    if (mem_redirect)               return 6'b111_111;
    if (!m_stalled && hazard())     return 6'b001_010;
    return 6'b111_000;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1; m_stalled = 0; m_ev = 0; m_stall = 0; m_flush = 0;
    end else if (m_ok && !ext_hold) begin
      if (mem_redirect) begin
        m_stalled = 0; m_ev = 0; m_flush++;
      end else if (!m_stalled && hazard()) begin
        m_stalled = 1; m_ev = 0; m_stall++;
      end else begin
        m_stalled = 0; m_ev = 1;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [5:0] e;
    if (m_ok) begin
      e = exp_ctl();
      cmp("ctl_a", int'({pc_we_a, ifid_we_a, pipe_we_a, ifid_flush_a, idex_bubble_a, exmem_flush_a}), int'(e));
      cmp("ctl_b", int'({pc_we_b, ifid_we_b, pipe_we_b, ifid_flush_b, idex_bubble_b, exmem_flush_b}), int'(e));
      cmp("ex_valid_a", int'(ex_valid_a), int'(m_ev));
      cmp("ex_valid_b", int'(ex_valid_b), int'(m_ev));
      cmp("stall_cnt_a", int'(stall_cnt_a), sat(m_stall, 16));
      cmp("flush_cnt_a", int'(flush_cnt_a), sat(m_flush, 16));
      cmp("stall_cnt_b", int'(stall_cnt_b), sat(m_stall, 2));
      cmp("flush_cnt_b", int'(flush_cnt_b), sat(m_flush, 2));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic apply(input logic r, input logic h, input logic rd, input logic mr,
                       input logic [4:0] xrt, input logic [4:0] rs, input logic [4:0] rt,
                       input logic u);
    @(posedge clk);
    #1;
    rst = r; ext_hold = h; mem_redirect = rd; ex_memread = mr;
    ex_rt = xrt; id_rs = rs; id_rt = rt; id_uses_rt = u;
    @(negedge clk);
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 1'b0);
  endtask

  initial begin
    rst = 1; ext_hold = 0; mem_redirect = 0; ex_memread = 0;
    ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("rst_pc_we", int'(pc_we_a), 0);
    cmp("rst_idex_bubble", int'(idex_bubble_a), 1);
    cmp("rst_pipe_we", int'(pipe_we_a), 1);

    idle();
    cmp("post_rst_ex_valid", int'(ex_valid_a), 0);
    cmp("post_rst_stall_cnt", int'(stall_cnt_a), 0);
    idle();
    cmp("normal_ex_valid", int'(ex_valid_a), 1);

    // load-use on rs: one stall cycle then normal flow
    apply(0, 0, 0, 1, 5'd8, 5'd8, 5'd1, 1'b0);
    cmp("lu_rs_pc_we", int'(pc_we_a), 0);
    cmp("lu_rs_bubble", int'(idex_bubble_a), 1);
    apply(0, 0, 0, 1, 5'd8, 5'd8, 5'd1, 1'b0);
    cmp("lu_second_pc_we", int'(pc_we_a), 1);
    cmp("lu_second_bubble", int'(idex_bubble_a), 0);
    cmp("lu_stall_cnt", int'(stall_cnt_a), 1);

    // register zero never stalls
    apply(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1'b1);
    cmp("r0_pc_we", int'(pc_we_a), 1);
    idle();
    cmp("r0_stall_cnt", int'(stall_cnt_a), 1);

    // rt match only counts when rt is a source
    apply(0, 0, 0, 1, 5'd9, 5'd3, 5'd9, 1'b0);
    cmp("rt_unused_pc_we", int'(pc_we_a), 1);
    apply(0, 0, 0, 1, 5'd9, 5'd3, 5'd9, 1'b1);
    cmp("rt_used_pc_we", int'(pc_we_a), 0);
    idle();
    cmp("rt_used_stall_cnt", int'(stall_cnt_a), 2);

    // redirect wins over a simultaneous hazard
    apply(0, 0, 1, 1, 5'd8, 5'd8, 5'd1, 1'b0);
    cmp("redir_flushes", int'({ifid_flush_a, idex_bubble_a, exmem_flush_a}), 7);
    cmp("redir_pc_we", int'(pc_we_a), 1);
    apply(0, 0, 0, 1, 5'd8, 5'd8, 5'd1, 1'b0);
    cmp("redir_flush_cnt", int'(flush_cnt_a), 1);
    cmp("redir_stall_cnt", int'(stall_cnt_a), 2);
    cmp("redir_then_run_stall", int'(pc_we_a), 0);

    // hold for three cycles while in the stall state
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 1, 5'd8, 5'd8, 5'd1, 1'b0);
      cmp("hold_we", int'({pc_we_a, ifid_we_a, pipe_we_a}), 0);
      cmp("hold_stall_cnt", int'(stall_cnt_a), 3);
    end
    apply(0, 0, 0, 1, 5'd8, 5'd8, 5'd1, 1'b0);
    cmp("hold_release_pc_we", int'(pc_we_a), 1);
    cmp("hold_release_bubble", int'(idex_bubble_a), 0);
    apply(0, 0, 0, 1, 5'd8, 5'd8, 5'd1, 1'b0);
    cmp("back_in_run_pc_we", int'(pc_we_a), 0);
    idle();
    cmp("stall_cnt_4", int'(stall_cnt_a), 4);
    cmp("stall_cnt_sat2", int'(stall_cnt_b), 3);

    // five redirects saturate the 2-bit counter
    for (int i = 0; i < 5; i++) apply(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1'b0);
    idle();
    cmp("flush_cnt_6", int'(flush_cnt_a), 6);
    cmp("flush_cnt_sat2", int'(flush_cnt_b), 3);

    // reset overrides hold and redirect
    apply(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 1'b0);
    cmp("rst_ovr_ctl", int'({pc_we_a, ifid_we_a, pipe_we_a, ifid_flush_a}), 4'b0011);
    idle();
    cmp("rst2_counters", int'({stall_cnt_b, flush_cnt_b}), 0);
    cmp("rst2_ex_valid", int'(ex_valid_b), 0);

    // reset during a stall leaves no residual stall
    apply(0, 0, 0, 1, 5'd7, 5'd7, 5'd0, 1'b0);
    cmp("pre_rst_stall", int'(pc_we_a), 0);
    apply(1, 0, 0, 1, 5'd7, 5'd7, 5'd0, 1'b0);
    apply(0, 0, 0, 1, 5'd7, 5'd7, 5'd0, 1'b0);
    cmp("after_rst_stall_again", int'(pc_we_a), 0);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
